// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample/slot widths and stereo sample types,
// imported by both the transmitter and the capture side.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;
    localparam int I2S_SLOT_W = 32;

    typedef logic signed [I2S_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_edge_det.sv
// SCK edge strobes and WS transition detect, all in the clk_i domain.
// ws_edge fires only on an SCK falling edge where WS differs from its last sampled value.
module i2s_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic ws_i,
    output logic sck_fall_o,
    output logic sck_rise_o,
    output logic ws_edge_o
);

    logic sck_q, sck_d;
    logic ws_last_q, ws_last_d;

    always_comb begin
        sck_d      = sck_i;
        sck_fall_o = sck_q & ~sck_i;
        sck_rise_o = ~sck_q & sck_i;
        ws_edge_o  = sck_fall_o & (ws_i != ws_last_q);
        ws_last_d  = sck_fall_o ? ws_i : ws_last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q     <= 1'b0;
            ws_last_q <= 1'b0;
        end else begin
            sck_q     <= sck_d;
            ws_last_q <= ws_last_d;
        end
    end

endmodule

// File: rtl/i2s_transmit_24.sv
// I2S transmitter: 1-deep staged stereo pair, serialised MSB-first one SCK after each WS edge.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module i2s_transmit_24
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int SLOT_W = I2S_SLOT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic signed [DATA_W-1:0] left_i,
    input  logic signed [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt_o
`endif
);

    localparam int PAD_W = SLOT_W - DATA_W;

    logic sck_fall, ws_edge, sck_rise_unused;

    i2s_edge_det u_edge_det (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (sck_i),
        .ws_i       (ws_i),
        .sck_fall_o (sck_fall),
        .sck_rise_o (sck_rise_unused),
        .ws_edge_o  (ws_edge)
    );

    logic              stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic [DATA_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [SLOT_W-1:0] shreg_q, shreg_d;
    logic              sd_q, sd_d;
    logic              underrun_q, underrun_d;
    logic              synced_q, synced_d;
    logic              transfer, frame_start, run;

    always_comb begin
        transfer      = valid_i & ~stage_valid_q;
        frame_start   = ws_edge & ~ws_i;
        // The very first left-slot start is already a fully live frame.
        run           = synced_q | frame_start;

        stage_valid_d = stage_valid_q;
        stage_l_d     = stage_l_q;
        stage_r_d     = stage_r_q;
        act_l_d       = act_l_q;
        act_r_d       = act_r_q;
        shreg_d       = shreg_q;
        sd_d          = sd_q;
        underrun_d    = 1'b0;
        synced_d      = synced_q;

        if (transfer) begin
            stage_valid_d = 1'b1;
            stage_l_d     = left_i;
            stage_r_d     = right_i;
        end

        // Staging is full whenever it is consumed here, so no transfer can collide.
        if (frame_start) begin
            synced_d = 1'b1;
            if (stage_valid_q) begin
                act_l_d       = stage_l_q;
                act_r_d       = stage_r_q;
                stage_valid_d = 1'b0;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end

        if (ws_edge && run) begin
            shreg_d = {(ws_i ? act_r_q : act_l_d), {PAD_W{1'b0}}};
            sd_d    = 1'b0;
        end else if (sck_fall && synced_q) begin
            sd_d    = shreg_q[SLOT_W-1];
            shreg_d = {shreg_q[SLOT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_valid_q <= 1'b0;
            stage_l_q     <= '0;
            stage_r_q     <= '0;
            act_l_q       <= '0;
            act_r_q       <= '0;
            shreg_q       <= '0;
            sd_q          <= 1'b0;
            underrun_q    <= 1'b0;
            synced_q      <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_l_q     <= stage_l_d;
            stage_r_q     <= stage_r_d;
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
            shreg_q       <= shreg_d;
            sd_q          <= sd_d;
            underrun_q    <= underrun_d;
            synced_q      <= synced_d;
        end
    end

    assign ready_o    = ~stage_valid_q;
    assign sd_o       = sd_q;
    assign underrun_o = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_transmit_24.sv
// Bench for i2s_transmit_24: generates SCK/WS, pushes sample pairs and decodes sd_o slot by slot
// against a queue-based frame model; with I2S_TX_UNDERRUN_CNT_EN also checks the underrun counter.
module tb_i2s_transmit_24;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        sck_i = 1'b0;
    logic        ws_i = 1'b0;
    logic [23:0] left_i, right_i;
    logic        valid_i;
    logic        ready_o, sd_o, underrun_o;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Clock and reset-free cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_transmit_24 dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sck_i      (sck_i),
        .ws_i       (ws_i),
        .left_i     (left_i),
        .right_i    (right_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .sd_o       (sd_o),
        .underrun_o (underrun_o)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o (underrun_cnt_o)
`endif
    );

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: accepted pairs in arrival order, consumed one per left-slot start
    logic [47:0] acc_q[$];
    int          acc_cyc_q[$];
    bit          m_synced = 0;
    logic [23:0] fr_l = '0, fr_r = '0;
    int          ur_exp_total = 0, ur_obs_total = 0, ur_since_rst = 0;
    bit          ur_chk_pending = 0, ur_chk_exp = 0;

    // SCK/WS generator and slot decoder state
    int          div = 0, falls_in_slot = 0, rise_cnt = 0;
    logic [31:0] slot_word = '0, slot_mask = '0;
    logic [23:0] slot_exp = '0;
    bit          slot_valid = 0, rst_seen = 0, slot_ws = 0, fs_next = 0;

    task automatic slot_start();
        if (slot_valid && rise_cnt == 32) begin
            if (rst_seen)
                check1(slot_ws ? "right_zero_after_reset" : "left_zero_after_reset",
                       slot_word & slot_mask, 32'h0);
            else
                check1(slot_ws ? "right_slot" : "left_slot", slot_word, {1'b0, slot_exp, 7'b0});
        end
        slot_valid = 1;
        rise_cnt   = 0;
        rst_seen   = rst_i;
        slot_word  = '0;
        slot_mask  = '0;
        slot_ws    = ws_i;
        if (!ws_i && !rst_i) begin
            m_synced = 1;
            if (acc_q.size() > 0 && acc_cyc_q[0] < cyc) begin
                {fr_l, fr_r} = acc_q.pop_front();
                void'(acc_cyc_q.pop_front());
                ur_chk_exp = 0;
            end else begin
                fr_l = '0;
                fr_r = '0;
                ur_chk_exp = 1;
                ur_exp_total++;
                ur_since_rst++;
            end
            ur_chk_pending = 1;
        end
        slot_exp = !m_synced ? 24'h0 : (ws_i ? fr_r : fr_l);
    endtask

    // SCK toggles every 4 clk, WS every 32 SCK; sd_o sampled just before each SCK rise
    always @(negedge clk) begin
        if (rst_i) begin
            acc_q.delete();
            acc_cyc_q.delete();
            m_synced       = 0;
            fr_l           = '0;
            fr_r           = '0;
            ur_chk_pending = 0;
            rst_seen       = 1;
            ur_since_rst   = 0;
        end
        if (ur_chk_pending) begin
            ur_chk_pending = 0;
            check1("underrun_at_frame_start", {31'b0, underrun_o}, {31'b0, ur_chk_exp});
            if (!ur_chk_exp) check1("ready_after_frame_start", {31'b0, ready_o}, 32'h1);
        end
        if (underrun_o === 1'b1) ur_obs_total++;
        if (div == 3) begin
            div = 0;
            if (sck_i) begin
                sck_i = 1'b0;
                if (falls_in_slot == 31) begin
                    falls_in_slot = 0;
                    ws_i = ~ws_i;
                    slot_start();
                end else begin
                    falls_in_slot++;
                end
            end else begin
                slot_word = {slot_word[30:0], sd_o};
                slot_mask = {slot_mask[30:0], rst_seen};
                rise_cnt++;
                sck_i = 1'b1;
            end
        end else begin
            div++;
        end
        fs_next = (div == 3) && sck_i && ws_i && (falls_in_slot == 31);
    end

    // Driver: called at a negedge, holds valid_i until the pair is accepted, returns at a negedge
    task automatic push(input logic [23:0] l, input logic [23:0] r);
        int t;
        bit rdy;
        valid_i = 1'b1;
        left_i  = l;
        right_i = r;
        t   = 0;
        rdy = 0;
        while (!rdy && t < 2000) begin
            rdy = ready_o;
            @(posedge clk);
            if (rdy) begin
                acc_q.push_back({l, r});
                acc_cyc_q.push_back(cyc);
            end
            @(negedge clk);
            t++;
        end
        check1("push_accepted", {31'b0, rdy}, 32'h1);
        check1("ready_low_after_accept", {31'b0, ready_o}, 32'h0);
    endtask

    task automatic wait_frames(input int n);
        repeat (n * 512) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [23:0] rl, rr;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        left_i  = '0;
        right_i = '0;
        repeat (4) @(negedge clk);
        check1("reset_sd_o", {31'b0, sd_o}, 32'h0);
        check1("reset_underrun_o", {31'b0, underrun_o}, 32'h0);
        check1("reset_ready_o", {31'b0, ready_o}, 32'h1);
        rst_i = 1'b0;
        @(negedge clk);

        // Directed pairs, then random ones with valid_i held high throughout
        push(24'h123456, 24'hABCDEF);
        push(24'h7FFFFF, 24'h800000);
        push(24'h000001, 24'hFFFFFF);
        for (int i = 0; i < 6; i++) begin
            rl = 24'($urandom());
            rr = 24'($urandom_range(0, 32'h00FFFFFF));
            push(rl, rr);
        end
        valid_i = 1'b0;

        // Starve the transmitter: drains the last pair, then underruns
        wait_frames(4);

        // Push landing exactly on a frame-start edge with staging empty
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!fs_next && t < 2000);
        check1("fs_edge_found", {31'b0, (t < 2000)}, 32'h1);
        @(negedge clk);
        push(24'h55AA55, 24'hFFF0FF);
        valid_i = 1'b0;

        // Reset in the middle of the right slot carrying 24'hFFF0FF
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (!(fr_r == 24'hFFF0FF && ws_i && falls_in_slot == 10) && t < 4000);
        check1("mid_right_slot_found", {31'b0, (t < 4000)}, 32'h1);
        @(negedge clk);
        check1("sd_o_before_reset", {31'b0, sd_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        check1("sd_o_async_reset", {31'b0, sd_o}, 32'h0);
        check1("ready_in_reset", {31'b0, ready_o}, 32'h1);
        check1("underrun_in_reset", {31'b0, underrun_o}, 32'h0);
        repeat (10) @(negedge clk);
        rst_i = 1'b0;
        push(24'h0F0F0F, 24'hC3C3C3);
        valid_i = 1'b0;
        wait_frames(3);

        check1("underrun_pulse_total", ur_obs_total, ur_exp_total);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check1("underrun_cnt", {16'b0, underrun_cnt_o}, ur_since_rst);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
